// File: rtl/roll_display_ctrl.sv
// rtl/roll_display_ctrl.sv - dice-roll display controller: debounced button, spin/slow-down/hold sequencing, 7-segment decode
module roll_display_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BASE_DELAY      = 4,
  parameter int SPIN_STEPS      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rnd_data,
  input  logic       rnd_valid,
  input  logic       roll_btn,
  output logic [6:0] seg_lo,
  output logic [6:0] seg_hi,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       busy,
  output logic [1:0] state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SPIN = 2'd1;
  localparam logic [1:0] ST_SLOW = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  localparam int              DB_W       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0]     BASE_VAL   = 16'(BASE_DELAY);
  localparam logic [7:0]      STEPS_VAL  = 8'(SPIN_STEPS);

  logic            btn_db;
  logic [DB_W-1:0] db_cnt;
  logic            db_flip;
  logic            press;
  logic            release_ev;

  logic [7:0]  disp_reg;
  logic [15:0] delay;
  logic [15:0] wait_cnt;
  logic [7:0]  step_cnt;

  logic [1:0]  state_next;
  logic        slow_update;
  logic        last_step;
  logic [7:0]  step_cnt_inc;
  logic [15:0] delay_dbl;
  logic [15:0] wait_inc;

  // The debounced level flips on the edge where the disagreeing streak reaches
  // its full length; press/release are taken from that same cycle so the FSM
  // moves on the very edge btn_db changes.
  assign db_flip    = (roll_btn != btn_db) && (db_cnt == DB_LAST);
  assign press      = db_flip && roll_btn;
  assign release_ev = db_flip && !roll_btn;

  // Debounce: count consecutive samples disagreeing with btn_db, restart on any agreeing sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else if (roll_btn != btn_db) begin
      if (db_cnt == DB_LAST) begin
        btn_db <= roll_btn;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Slow-down arithmetic: saturating wait counter and doubling delay.
  always_comb begin
    step_cnt_inc = step_cnt + 8'd1;
    delay_dbl    = delay[15] ? 16'hFFFF : {delay[14:0], 1'b0};
    wait_inc     = (wait_cnt == 16'hFFFF) ? 16'hFFFF : wait_cnt + 16'd1;
    slow_update  = (state == ST_SLOW) && rnd_valid && (wait_cnt >= delay);
    last_step    = slow_update && (step_cnt_inc == STEPS_VAL);
  end

  // Next-state selection; press in SLOW and release outside SPIN fall through untouched.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (press)      state_next = ST_SPIN;
      ST_SPIN: if (release_ev) state_next = ST_SLOW;
      ST_SLOW: if (last_step)  state_next = ST_HOLD;
      ST_HOLD: if (press)      state_next = ST_SPIN;
      default:                 state_next = ST_IDLE;
    endcase
  end

  // Sequencer state, display register, slow-down counters and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      disp_reg     <= 8'h00;
      result       <= 8'h00;
      result_valid <= 1'b0;
      delay        <= 16'h0000;
      wait_cnt     <= 16'h0000;
      step_cnt     <= 8'h00;
    end else begin
      state        <= state_next;
      busy         <= (state_next == ST_SPIN) || (state_next == ST_SLOW);
      result_valid <= 1'b0;
      case (state)
        ST_SPIN: begin
          if (rnd_valid) begin
            disp_reg <= rnd_data;
          end
          if (release_ev) begin
            step_cnt <= 8'h00;
            delay    <= BASE_VAL;
            wait_cnt <= 16'h0000;
          end
        end
        ST_SLOW: begin
          if (slow_update) begin
            disp_reg <= rnd_data;
            wait_cnt <= 16'h0000;
            step_cnt <= step_cnt_inc;
            delay    <= delay_dbl;
            if (last_step) begin
              result       <= rnd_data;
              result_valid <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_inc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Hex to active-high {g,f,e,d,c,b,a} segment pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Segment outputs follow disp_reg combinationally.
  always_comb begin
    seg_lo = hex_to_seg(disp_reg[3:0]);
    seg_hi = hex_to_seg(disp_reg[7:4]);
  end

endmodule

// File: tb/tb_roll_display_ctrl.sv
// tb/tb_roll_display_ctrl.sv - scoreboard bench for roll_display_ctrl
module tb_roll_display_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rnd_data;
  logic       rnd_valid;
  logic       roll_btn;
  logic [6:0] seg_lo;
  logic [6:0] seg_hi;
  logic [7:0] result;
  logic       result_valid;
  logic       busy;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  roll_display_ctrl #(
    .DEBOUNCE_CYCLES(16),
    .BASE_DELAY(4),
    .SPIN_STEPS(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rnd_data(rnd_data),
    .rnd_valid(rnd_valid),
    .roll_btn(roll_btn),
    .seg_lo(seg_lo),
    .seg_hi(seg_hi),
    .result(result),
    .result_valid(result_valid),
    .busy(busy),
    .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[n];
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_disp(input string name, input logic [7:0] b);
    chk(name, {2'b00, seg_hi, seg_lo}, {2'b00, seg7(b[7:4]), seg7(b[3:0])});
  endtask

  // Monitor: every result_valid pulse is matched against the next queued roll value.
  initial begin
    logic prev;
    logic [7:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (result_valid) begin
        chk("rv_spacing", 16'(prev), 16'h0000);
        if (exp_q.size() == 0) begin
          chk("rv_unexpected", 16'(result_valid), 16'h0000);
        end else begin
          e = exp_q.pop_front();
          chk("result", 16'(result), 16'(e));
        end
      end
      prev = result_valid;
    end
  end

  task automatic press(input string tag, input logic [1:0] from_state);
    roll_btn = 1'b1;
    repeat (15) @(negedge clk);
    chk({tag, "_pre"}, 16'(state), 16'(from_state));
    @(negedge clk);
    chk({tag, "_state"}, 16'(state), 16'(2'd1));
    chk({tag, "_busy"}, 16'(busy), 16'h0001);
  endtask

  task automatic run_slow(input logic [7:0] base, input logic [7:0] prev_disp, input int abort_idx);
    roll_btn  = 1'b0;
    rnd_valid = 1'b0;
    repeat (15) @(negedge clk);
    chk("rel_pre", 16'(state), 16'(2'd1));
    @(negedge clk);
    chk("rel_slow", 16'(state), 16'(2'd2));
    chk("rel_busy", 16'(busy), 16'h0001);
    if (abort_idx < 0) exp_q.push_back(base + 8'd30);
    rnd_valid = 1'b1;
    for (int idx = 0; idx <= 30; idx++) begin
      rnd_data = base + 8'(idx);
      if (idx == abort_idx) reset = 1'b1;
      @(negedge clk);
      if (idx == abort_idx) begin
        reset = 1'b0;
        chk("abort_state", 16'(state), 16'h0000);
        chk_disp("abort_disp", 8'h00);
        chk("abort_result", 16'(result), 16'h0000);
        chk("abort_busy", 16'(busy), 16'h0000);
        chk("abort_rv", 16'(result_valid), 16'h0000);
        repeat (40) @(negedge clk);
        chk("abort_idle", 16'(state), 16'h0000);
        rnd_valid = 1'b0;
        return;
      end
      case (idx)
        3:  chk_disp("slow_i3", prev_disp);
        4:  chk_disp("slow_i4", base + 8'd4);
        12: chk_disp("slow_i12", base + 8'd4);
        13: chk_disp("slow_i13", base + 8'd13);
        29: begin
          chk("slow_i29_state", 16'(state), 16'(2'd2));
          chk_disp("slow_i29_disp", base + 8'd13);
        end
        30: begin
          chk("slow_i30_state", 16'(state), 16'(2'd3));
          chk_disp("slow_i30_disp", base + 8'd30);
          chk("slow_i30_busy", 16'(busy), 16'h0000);
          chk("slow_i30_rv", 16'(result_valid), 16'h0001);
        end
        default: begin
        end
      endcase
    end
    repeat (3) begin
      rnd_data = rnd_data + 8'd7;
      @(negedge clk);
    end
    chk_disp("hold_disp", base + 8'd30);
    chk("hold_state", 16'(state), 16'(2'd3));
    chk("hold_result", 16'(result), 16'(base + 8'd30));
    rnd_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    rnd_valid = 1'b0;
    rnd_data  = 8'h00;
    roll_btn  = 1'b0;
    @(negedge clk);
    chk("rst_seg_lo", 16'(seg_lo), 16'h003F);
    chk("rst_seg_hi", 16'(seg_hi), 16'h003F);
    chk("rst_result", 16'(result), 16'h0000);
    chk("rst_state", 16'(state), 16'h0000);
    chk("rst_busy", 16'(busy), 16'h0000);
    chk("rst_rv", 16'(result_valid), 16'h0000);
    reset = 1'b0;

    roll_btn = 1'b1;
    repeat (15) @(negedge clk);
    roll_btn = 1'b0;
    repeat (3) @(negedge clk);
    chk("glitch15_state", 16'(state), 16'h0000);
    chk("glitch15_busy", 16'(busy), 16'h0000);

    press("press1", 2'd0);

    rnd_valid = 1'b1;
    rnd_data  = 8'hA5;
    @(negedge clk);
    rnd_valid = 1'b0;
    chk("spin_a5_hi", 16'(seg_hi), 16'h0077);
    chk("spin_a5_lo", 16'(seg_lo), 16'h006D);

    run_slow(8'h00, 8'hA5, -1);

    press("press_hold1", 2'd3);
    chk("hold1_result", 16'(result), 16'h001E);

    run_slow(8'h3E, 8'h1E, -1);

    press("press_hold2", 2'd3);
    chk("hold2_result", 16'(result), 16'h005C);
    chk("hold2_rv", 16'(result_valid), 16'h0000);
    repeat (3) @(negedge clk);
    chk("hold2_result_late", 16'(result), 16'h005C);

    run_slow(8'h80, 8'h5C, 10);

    reset    = 1'b1;
    roll_btn = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    press("post_reset", 2'd0);

    roll_btn = 1'b0;
    repeat (5) @(negedge clk);
    chk("queue_empty", 16'(exp_q.size()), 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/roll_display_ctrl.md
ROLL_DISPLAY_CTRL -- requirements
Module: roll_display_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive identical samples needed to change the debounced button level (≥2).
REQ-002 The block SHALL have parameter BASE_DELAY, default 4: initial inter-update wait in SLOW (1..32767).
REQ-003 The block SHALL have parameter SPIN_STEPS, default 8: number of accepted updates in SLOW before HOLD (1..255).
REQ-004 The block SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 The block SHALL have port reset  in  1  reset; it is synchronous and active-high.
REQ-006 The block SHALL have port rnd_data  in  8  random byte from the upstream PRNG mux.
REQ-007 The block SHALL have port rnd_valid  in  1  single-cycle qualifier for rnd_data.
REQ-008 The block SHALL have port roll_btn  in  1  raw roll button, already synchronised to clk, active-high.
REQ-009 The block SHALL have port seg_lo  out  7  segments {g,f,e,d,c,b,a} of disp_reg[3:0], active-high.
REQ-010 The block SHALL have port seg_hi  out  7  segments of disp_reg[7:4].
REQ-011 The block SHALL have port result  out  8  last completed roll value.
REQ-012 The block SHALL have port result_valid  out  1  one-cycle pulse when result is updated.
REQ-013 The block SHALL have port busy  out  1  high in SPIN or SLOW.
REQ-014 The block SHALL have port state  out  2  IDLE=0, SPIN=1, SLOW=2, HOLD=3.

Function
REQ-015 Debounce: the debounced level btn_db SHALL toggle only after roll_btn has differed from btn_db for DEBOUNCE_CYCLES consecutive cycles; any agreeing sample clears the counter.
REQ-016 press = btn_db 0→1 and release = btn_db 1→0; each SHALL be a one-cycle internal event.
REQ-017 Segment decode SHALL be combinational from disp_reg, hex 0-F = 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
REQ-018 IDLE: rnd_valid ignored; press → SPIN.
REQ-019 SPIN: on every cycle with rnd_valid=1, disp_reg SHALL load rnd_data; release → SLOW with step_cnt=0, delay=BASE_DELAY, wait_cnt=0.
REQ-020 SLOW: wait_cnt SHALL increment each cycle (saturating at 0xFFFF); an update SHALL occur in a cycle where wait_cnt ≥ delay and rnd_valid=1: disp_reg←rnd_data, wait_cnt←0, step_cnt+1, delay←min(2·delay, 0xFFFF).
REQ-021 The update that makes step_cnt equal SPIN_STEPS SHALL transition to HOLD, load result with the same rnd_data, and assert result_valid for exactly the following cycle.
REQ-022 Press events in SLOW SHALL be ignored; release events outside SPIN SHALL be ignored.
REQ-023 HOLD: disp_reg and result SHALL be held; rnd_valid ignored; press → SPIN (result retained).
REQ-024 busy SHALL be registered state-decoded (SPIN or SLOW); result_valid SHALL never be high on two consecutive cycles.
REQ-025 delay and wait_cnt SHALL be 16 bits; step_cnt 8 bits.

Reset
REQ-026 With reset high at a clock edge, all registers SHALL clear: state=IDLE, disp_reg=0x00 (seg_lo=seg_hi=0x3F), result=0x00, result_valid=0, busy=0, btn_db=0, all counters 0.
REQ-027 Reset SHALL take priority over every event, including an in-progress SLOW update or result_valid pulse.
REQ-028 After reset release with roll_btn already high, a press SHALL be recognised only after DEBOUNCE_CYCLES cycles.

Verification
REQ-029 Reset 1 cycle -> seg_lo=seg_hi=0x3F, result=0x00, state=0, busy=0, result_valid=0.
REQ-030 roll_btn high 15 cycles then low (default params) -> state stays 0; held 16 cycles -> state=1, busy=1.
REQ-031 In SPIN, rnd_valid=1 with rnd_data=0xA5 -> next cycle seg_hi=0x77, seg_lo=0x6D.
REQ-032 BASE_DELAY=4, SPIN_STEPS=3, rnd_valid=1 each cycle, rnd_data = cycle count -> updates at SLOW-cycle indices 4, 13, 30; state=3 after the third; one result_valid pulse; result = third accepted byte.
REQ-033 Reset asserted at SLOW index 10 -> state=0, display 0x3F/0x3F, no result_valid thereafter.
REQ-034 In HOLD with result=0x5C, debounced press -> state=1, result stays 0x5C, result_valid stays 0.
